// File: rtl/ms_serial_mouse_rx.sv
// ms_serial_mouse_rx: Microsoft serial mouse host receiver (RTS power-up, M ident, 7N1 deframing, 3-byte packet decode)
module ms_serial_mouse_rx #(
  parameter int CLKFREQ    = 50_000_000,
  parameter int BAUD       = 1_200,
  parameter int RTS_LOW_MS = 100,
  parameter int IDENT_MS   = 200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  input  logic       reinit,
  output logic       rts,
  output logic       mouse_present,
  output logic       pkt_valid,
  output logic [7:0] dx,
  output logic [7:0] dy,
  output logic       lbut,
  output logic       rbut,
  output logic       frame_err
);
  localparam int BIT      = CLKFREQ / BAUD;
  localparam int CW       = $clog2(BIT + 1);
  localparam int RTSLOW_N = int'(longint'(RTS_LOW_MS) * longint'(CLKFREQ) / 64'sd1000);
  localparam int IDENT_N  = int'(longint'(IDENT_MS) * longint'(CLKFREQ) / 64'sd1000);
  localparam int TMAX     = RTSLOW_N > IDENT_N ? RTSLOW_N : IDENT_N;
  localparam int TW       = $clog2(TMAX + 1);
  localparam logic [TW-1:0] RTSLOW_END = TW'(RTSLOW_N - 1);
  localparam logic [TW-1:0] IDENT_END  = TW'(IDENT_N - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
  typedef enum logic [1:0] {T_RTSLOW, T_IDENT, T_RUN} top_t;

  logic [2:0]    sync_q, sync_d;
  rx_t           rx_q, rx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    nbit_q, nbit_d;
  logic [6:0]    sh_q, sh_d;
  logic          byte_ok_q, byte_ok_d, ferr_q, ferr_d;
  top_t          t_q, t_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          rts_q, rts_d, pres_q, pres_d, pkt_q, pkt_d;
  logic [1:0]    idx_q, idx_d, xh_q, xh_d, yh_q, yh_d;
  logic [5:0]    xl_q, xl_d;
  logic          lb_q, lb_d, rb_q, rb_d, lbut_q, lbut_d, rbut_q, rbut_d;
  logic [7:0]    dx_q, dx_d, dy_q, dy_d;
  logic          rx_in, fall, tick;

  // sync_q[1] is the synchronised line, sync_q[2] its previous value for edge detection
  assign sync_d = {sync_q[1:0], rxd};
  assign rx_in  = sync_q[1];
  assign fall   = sync_q[2] & ~sync_q[1];
  assign tick   = cnt_q == CW'(1);

  always_comb begin
    rx_d      = rx_q;
    cnt_d     = cnt_q - CW'(1);
    nbit_d    = nbit_q;
    sh_d      = sh_q;
    byte_ok_d = 1'b0;
    ferr_d    = 1'b0;
    case (rx_q)
      RX_IDLE: if (fall) begin
        rx_d  = RX_START;
        cnt_d = CW'(BIT / 2);
      end
      RX_START: if (tick) begin
        rx_d   = rx_in ? RX_IDLE : RX_DATA;
        cnt_d  = CW'(BIT);
        nbit_d = 3'd0;
      end
      RX_DATA: if (tick) begin
        sh_d   = {rx_in, sh_q[6:1]};
        cnt_d  = CW'(BIT);
        nbit_d = nbit_q + 3'd1;
        rx_d   = nbit_q == 3'd6 ? RX_STOP : RX_DATA;
      end
      RX_STOP: if (tick) begin
        byte_ok_d = rx_in;
        ferr_d    = ~rx_in;
        rx_d      = RX_IDLE;
      end
      default: rx_d = RX_IDLE;
    endcase
    if (reinit) begin
      rx_d      = RX_IDLE;
      byte_ok_d = 1'b0;
      ferr_d    = 1'b0;
    end
  end

  always_comb begin
    t_d    = t_q;
    tmr_d  = tmr_q + TW'(1);
    rts_d  = rts_q;
    pres_d = pres_q;
    idx_d  = ferr_q ? 2'd0 : idx_q;
    lb_d   = lb_q;
    rb_d   = rb_q;
    xh_d   = xh_q;
    yh_d   = yh_q;
    xl_d   = xl_q;
    dx_d   = dx_q;
    dy_d   = dy_q;
    lbut_d = lbut_q;
    rbut_d = rbut_q;
    pkt_d  = 1'b0;
    case (t_q)
      T_RTSLOW: begin
        rts_d  = 1'b0;
        pres_d = 1'b0;
        if (tmr_q == RTSLOW_END) begin
          t_d   = T_IDENT;
          tmr_d = '0;
          rts_d = 1'b1;
        end
      end
      T_IDENT: if (byte_ok_q && sh_q == 7'h4D) begin
        t_d    = T_RUN;
        pres_d = 1'b1;
        idx_d  = 2'd0;
      end else if (tmr_q == IDENT_END) begin
        t_d   = T_RTSLOW;
        tmr_d = '0;
        rts_d = 1'b0;
      end
      T_RUN: if (byte_ok_q) begin
        // a byte with bit6 set always starts a packet, even mid-packet
        if (sh_q[6]) begin
          lb_d  = sh_q[5];
          rb_d  = sh_q[4];
          yh_d  = sh_q[3:2];
          xh_d  = sh_q[1:0];
          idx_d = 2'd1;
        end else if (idx_q == 2'd1) begin
          xl_d  = sh_q[5:0];
          idx_d = 2'd2;
        end else if (idx_q == 2'd2) begin
          dx_d   = {xh_q, xl_q};
          dy_d   = {yh_q, sh_q[5:0]};
          lbut_d = lb_q;
          rbut_d = rb_q;
          pkt_d  = 1'b1;
          idx_d  = 2'd0;
        end
      end
      default: t_d = T_RTSLOW;
    endcase
    if (reinit) begin
      t_d    = T_RTSLOW;
      tmr_d  = '0;
      rts_d  = 1'b0;
      pres_d = 1'b0;
      idx_d  = 2'd0;
      pkt_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= 3'b111;
      rx_q      <= RX_IDLE;
      cnt_q     <= '0;
      nbit_q    <= '0;
      sh_q      <= '0;
      byte_ok_q <= 1'b0;
      ferr_q    <= 1'b0;
      t_q       <= T_RTSLOW;
      tmr_q     <= '0;
      rts_q     <= 1'b0;
      pres_q    <= 1'b0;
      pkt_q     <= 1'b0;
      idx_q     <= '0;
      xh_q      <= '0;
      yh_q      <= '0;
      xl_q      <= '0;
      lb_q      <= 1'b0;
      rb_q      <= 1'b0;
      lbut_q    <= 1'b0;
      rbut_q    <= 1'b0;
      dx_q      <= '0;
      dy_q      <= '0;
    end else begin
      sync_q    <= sync_d;
      rx_q      <= rx_d;
      cnt_q     <= cnt_d;
      nbit_q    <= nbit_d;
      sh_q      <= sh_d;
      byte_ok_q <= byte_ok_d;
      ferr_q    <= ferr_d;
      t_q       <= t_d;
      tmr_q     <= tmr_d;
      rts_q     <= rts_d;
      pres_q    <= pres_d;
      pkt_q     <= pkt_d;
      idx_q     <= idx_d;
      xh_q      <= xh_d;
      yh_q      <= yh_d;
      xl_q      <= xl_d;
      lb_q      <= lb_d;
      rb_q      <= rb_d;
      lbut_q    <= lbut_d;
      rbut_q    <= rbut_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
    end
  end

  assign rts           = rts_q;
  assign mouse_present = pres_q;
  assign pkt_valid     = pkt_q;
  assign dx            = dx_q;
  assign dy            = dy_q;
  assign lbut          = lbut_q;
  assign rbut          = rbut_q;
  assign frame_err     = ferr_q;
endmodule

// File: tb/tb_ms_serial_mouse_rx.sv
// tb_ms_serial_mouse_rx: directed bench with a timeline model of RTS/ident and packet decoding
module tb_ms_serial_mouse_rx;
  localparam int BITC  = 100;
  localparam int RTSN  = 120;
  localparam int IDN   = 240;
  localparam int CYCLE = RTSN + IDN;
  // falling edge driven after edge c0 -> 2 sync cycles, BIT/2 (+1 register) to start sample, 8 more bits to stop
  localparam int LAT   = 2 + BITC / 2 + 1 + 8 * BITC;

  logic clk = 1'b0, reset_n = 1'b0, rxd = 1'b1, reinit = 1'b0;
  logic rts, mouse_present, pkt_valid, lbut, rbut, frame_err;
  logic [7:0] dx, dy;

  ms_serial_mouse_rx #(.CLKFREQ(120_000), .BAUD(1200), .RTS_LOW_MS(1), .IDENT_MS(2)) dut (
    .clk(clk), .reset_n(reset_n), .rxd(rxd), .reinit(reinit),
    .rts(rts), .mouse_present(mouse_present), .pkt_valid(pkt_valid),
    .dx(dx), .dy(dy), .lbut(lbut), .rbut(rbut), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {int s; logic [6:0] b; bit ok;} ev_t;
  ev_t evq[$];
  int cyc = 0, checks = 0, failures = 0, pkt_cnt = 0, ferr_cnt = 0;
  int r = 0, idx = 0;
  bit run = 0, pres = 0, lb = 0, rb = 0, elb = 0, erb = 0, epkt = 0, eferr = 0, erts = 0;
  logic [1:0] xh = 0, yh = 0;
  logic [5:0] xl = 0;
  logic [7:0] edx = 0, edy = 0;

  task automatic chk(string n, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at cycle %0d", n, act, exp, cyc);
    end
  endtask

  // expected behaviour: rts follows a fixed 120-low / 240-high period from the last restart until M is seen
  initial forever begin
    @(posedge clk);
    if (reset_n) begin
      cyc++;
      epkt  = 0;
      eferr = 0;
      if (reinit) begin
        r = cyc; run = 0; pres = 0; idx = 0;
        evq.delete();
      end else if (evq.size() > 0 && evq[0].s == cyc - 1) begin
        ev_t e;
        e = evq.pop_front();
        if (!e.ok) idx = 0;
        else if (!run) begin
          if (((e.s - r) % CYCLE) >= RTSN && e.b == 7'h4D) begin
            run = 1; pres = 1; idx = 0;
          end
        end else if (e.b[6]) begin
          lb = e.b[5]; rb = e.b[4]; yh = e.b[3:2]; xh = e.b[1:0]; idx = 1;
        end else if (idx == 1) begin
          xl = e.b[5:0]; idx = 2;
        end else if (idx == 2) begin
          edx = {xh, xl}; edy = {yh, e.b[5:0]}; elb = lb; erb = rb; epkt = 1; idx = 0;
        end
      end
      if (evq.size() > 0 && evq[0].s == cyc && !evq[0].ok) eferr = 1;
      erts = run || (((cyc - r) % CYCLE) >= RTSN);
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      chk("rst_rts", {7'd0, rts}, 8'd0);
      chk("rst_present", {7'd0, mouse_present}, 8'd0);
      chk("rst_pkt_valid", {7'd0, pkt_valid}, 8'd0);
      chk("rst_frame_err", {7'd0, frame_err}, 8'd0);
      chk("rst_dx", dx, 8'd0);
      chk("rst_dy", dy, 8'd0);
      chk("rst_buttons", {6'd0, lbut, rbut}, 8'd0);
    end else begin
      chk("rts", {7'd0, rts}, {7'd0, erts});
      chk("mouse_present", {7'd0, mouse_present}, {7'd0, pres});
      chk("pkt_valid", {7'd0, pkt_valid}, {7'd0, epkt});
      chk("frame_err", {7'd0, frame_err}, {7'd0, eferr});
      chk("dx", dx, edx);
      chk("dy", dy, edy);
      chk("lbut", {7'd0, lbut}, {7'd0, elb});
      chk("rbut", {7'd0, rbut}, {7'd0, erb});
      if (pkt_valid) pkt_cnt++;
      if (frame_err) ferr_cnt++;
    end
  end

  task automatic at_cyc(int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic send(logic [6:0] b, bit ok = 1);
    ev_t e;
    e.s = cyc + LAT; e.b = b; e.ok = ok;
    evq.push_back(e);
    rxd = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      rxd = b[i];
      repeat (BITC) @(negedge clk);
    end
    rxd = ok;
    repeat (BITC) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic send3(logic [6:0] a, logic [6:0] b, logic [6:0] c);
    send(a); send(b); send(c);
  endtask

  initial begin
    int p0, f0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    at_cyc(119); chk("rts_before_raise", {7'd0, rts}, 8'd0);
    at_cyc(120); chk("rts_raise", {7'd0, rts}, 8'd1);
    at_cyc(359); chk("rts_ident_end", {7'd0, rts}, 8'd1);
    at_cyc(360); chk("rts_timeout_drop", {7'd0, rts}, 8'd0);
    at_cyc(480); chk("rts_retry_raise", {7'd0, rts}, 8'd1);
    // M whose stop sample lands while rts is low must not be accepted
    at_cyc(597); send(7'h4D);
    at_cyc(1460); chk("m_while_rts_low", {7'd0, mouse_present}, 8'd0);
    at_cyc(1600);
    fork
      send(7'h4D);
      begin
        at_cyc(2453); chk("present_before", {7'd0, mouse_present}, 8'd0);
        at_cyc(2454); chk("present_after", {7'd0, mouse_present}, 8'd1);
      end
    join
    p0 = pkt_cnt; send3(7'h6C, 7'h05, 7'h3D);
    chk("pkt1_count", 8'(pkt_cnt - p0), 8'd1);
    chk("pkt1_dx", dx, 8'h05); chk("pkt1_dy", dy, 8'hFD);
    chk("pkt1_btn", {6'd0, lbut, rbut}, 8'b10);
    p0 = pkt_cnt; send3(7'h53, 7'h3F, 7'h00);
    chk("pkt2_count", 8'(pkt_cnt - p0), 8'd1);
    chk("pkt2_dx", dx, 8'hFF); chk("pkt2_dy", dy, 8'h00);
    chk("pkt2_btn", {6'd0, lbut, rbut}, 8'b01);
    p0 = pkt_cnt; send(7'h6C); send(7'h05); send3(7'h40, 7'h01, 7'h02);
    chk("resync_count", 8'(pkt_cnt - p0), 8'd1);
    chk("resync_dx", dx, 8'h01); chk("resync_dy", dy, 8'h02);
    chk("resync_btn", {6'd0, lbut, rbut}, 8'b00);
    p0 = pkt_cnt; send(7'h15);
    chk("stray_count", 8'(pkt_cnt - p0), 8'd0);
    p0 = pkt_cnt; f0 = ferr_cnt;
    send(7'h6C); send(7'h05, 0);
    repeat (200) @(negedge clk);
    send(7'h3D);
    chk("ferr_count", 8'(ferr_cnt - f0), 8'd1);
    chk("ferr_pkt_count", 8'(pkt_cnt - p0), 8'd0);
    chk("ferr_dx_held", dx, 8'h01);
    p0 = pkt_cnt;
    rxd = 1'b0; repeat (40) @(negedge clk); rxd = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch_pkt_count", 8'(pkt_cnt - p0), 8'd0);
    send3(7'h6C, 7'h05, 7'h3D);
    chk("post_glitch_count", 8'(pkt_cnt - p0), 8'd1);
    chk("post_glitch_dx", dx, 8'h05);
    p0 = pkt_cnt; send(7'h6C); send(7'h05);
    reinit = 1'b1; @(negedge clk);
    chk("reinit_rts", {7'd0, rts}, 8'd0);
    chk("reinit_present", {7'd0, mouse_present}, 8'd0);
    reinit = 1'b0;
    send(7'h3D);
    chk("reinit_pkt_count", 8'(pkt_cnt - p0), 8'd0);
    chk("reinit_present_held", {7'd0, mouse_present}, 8'd0);
    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
